// File: rtl/eth_rx_demux_if.sv
// Interface bundle for eth_rx_demux: the de-preambled GMII receive stream,
// the parsed header fields and the ARP / IPv4 payload channels.
// master: receive-stream source and output consumer; slave: the demux itself.
// Optional statistics outputs exist only when ETH_RX_DEMUX_STATS_EN is defined.
interface eth_rx_demux_if;
   logic [7:0]  rx_d;
   logic        rx_v;
   logic        rx_crc_err;
   logic [47:0] hdr_dst;
   logic [47:0] hdr_src;
   logic [15:0] hdr_type;
   logic        hdr_val;
   logic [7:0]  out_d;
   logic        arp_v;
   logic        ipv4_v;
   logic        arp_eof;
   logic        ipv4_eof;
   logic        err;
`ifdef ETH_RX_DEMUX_STATS_EN
   logic [31:0] cnt_ok;
   logic [31:0] cnt_drop;
   logic [31:0] cnt_err;
`endif

   modport master (
      output rx_d, rx_v, rx_crc_err,
      input  hdr_dst, hdr_src, hdr_type, hdr_val,
      input  out_d, arp_v, ipv4_v, arp_eof, ipv4_eof, err
`ifdef ETH_RX_DEMUX_STATS_EN
      , input cnt_ok, cnt_drop, cnt_err
`endif
   );

   modport slave (
      input  rx_d, rx_v, rx_crc_err,
      output hdr_dst, hdr_src, hdr_type, hdr_val,
      output out_d, arp_v, ipv4_v, arp_eof, ipv4_eof, err
`ifdef ETH_RX_DEMUX_STATS_EN
      , output cnt_ok, cnt_drop, cnt_err
`endif
   );
endinterface

// File: rtl/eth_rx_demux.sv
// Ethernet receive demultiplexer: parses the 14-byte header, filters on
// destination MAC, strips the FCS with a 4-byte delay line and steers the
// payload to the ARP or IPv4 channel. Errors (CRC, runt, oversize) qualify
// the end-of-frame strobe.
// Optional: define ETH_RX_DEMUX_STATS_EN for saturating ok/drop/err counters.
// MAX_PAYLOAD must not exceed 2047 (forwarded-byte counter is 11 bits).
module eth_rx_demux #(
   parameter int MAX_PAYLOAD = 1500,
   parameter bit PROMISC     = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [47:0]   dev_mac,
   eth_rx_demux_if.slave rx
);

   localparam logic [10:0] MAX_P = 11'(MAX_PAYLOAD);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_EOF, S_DROP} state_t;

   state_t       state;
   logic         rx_v_q;
   logic         armed;
   logic [10:0]  byte_cnt;
   logic [10:0]  fwd_cnt;
   logic         chan_ipv4;
   logic         oversize;
   logic [111:0] hdr_q;
   logic [7:0]   d_p0, d_p1, d_p2, d_p3;
   logic [7:0]   out_d_q;
   logic         hdr_val_q, arp_v_q, ipv4_v_q, arp_eof_q, ipv4_eof_q, err_q;

   logic         frame_start;
   logic [111:0] hdr_nxt;
   logic         mac_ok;
   logic         is_arp;
   logic         is_ipv4;
   logic [10:0]  cnt_inc;
   logic         err_nxt;

   // Header is one 112-bit shift chain: dst | src | type, MSB first.
   assign hdr_nxt     = {hdr_q[103:0], rx.rx_d};
   // armed blocks a frame that was already running when reset was released.
   assign frame_start = rx.rx_v & ~rx_v_q & armed;
   assign mac_ok      = PROMISC || (hdr_nxt[111:64] == dev_mac) ||
                        (hdr_nxt[111:64] == 48'hFFFF_FFFF_FFFF);
   assign is_arp      = (hdr_nxt[15:0] == 16'h0806);
   assign is_ipv4     = (hdr_nxt[15:0] == 16'h0800);
   assign cnt_inc     = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
   assign err_nxt     = rx.rx_crc_err | (byte_cnt < 11'd64) | oversize;

   assign rx.hdr_dst  = hdr_q[111:64];
   assign rx.hdr_src  = hdr_q[63:16];
   assign rx.hdr_type = hdr_q[15:0];
   assign rx.hdr_val  = hdr_val_q;
   assign rx.out_d    = out_d_q;
   assign rx.arp_v    = arp_v_q;
   assign rx.ipv4_v   = ipv4_v_q;
   assign rx.arp_eof  = arp_eof_q;
   assign rx.ipv4_eof = ipv4_eof_q;
   assign rx.err      = err_q;

   // 4-deep byte delay line: the last 4 bytes of a frame (FCS) never leave it.
   always_ff @(posedge clk) begin
      if (rx.rx_v) begin
         d_p0 <= rx.rx_d;
         d_p1 <= d_p0;
         d_p2 <= d_p1;
         d_p3 <= d_p2;
      end
   end

   // Frame FSM with registered header, payload and end-of-frame outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         rx_v_q     <= 1'b0;
         armed      <= 1'b0;
         byte_cnt   <= '0;
         fwd_cnt    <= '0;
         chan_ipv4  <= 1'b0;
         oversize   <= 1'b0;
         hdr_q      <= '0;
         out_d_q    <= '0;
         hdr_val_q  <= 1'b0;
         arp_v_q    <= 1'b0;
         ipv4_v_q   <= 1'b0;
         arp_eof_q  <= 1'b0;
         ipv4_eof_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rx_v_q     <= rx.rx_v;
         if (!rx.rx_v) armed <= 1'b1;
         out_d_q    <= '0;
         hdr_val_q  <= 1'b0;
         arp_v_q    <= 1'b0;
         ipv4_v_q   <= 1'b0;
         arp_eof_q  <= 1'b0;
         ipv4_eof_q <= 1'b0;
         err_q      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state    <= S_HDR;
                  hdr_q    <= hdr_nxt;
                  byte_cnt <= 11'd1;
                  fwd_cnt  <= '0;
                  oversize <= 1'b0;
               end
            end
            S_HDR: begin
               if (!rx.rx_v) begin
                  state <= S_IDLE;
               end else begin
                  hdr_q    <= hdr_nxt;
                  byte_cnt <= cnt_inc;
                  if (byte_cnt == 11'd13) begin
                     hdr_val_q <= 1'b1;
                     chan_ipv4 <= is_ipv4;
                     if (mac_ok && (is_arp || is_ipv4)) state <= S_PAY;
                     else                               state <= S_DROP;
                  end
               end
            end
            S_PAY: begin
               if (rx.rx_v) begin
                  byte_cnt <= cnt_inc;
                  // Byte k leaves the delay line when byte k+4 arrives.
                  if (byte_cnt >= 11'd18) begin
                     if (fwd_cnt != MAX_P) begin
                        out_d_q  <= d_p3;
                        arp_v_q  <= ~chan_ipv4;
                        ipv4_v_q <= chan_ipv4;
                        fwd_cnt  <= fwd_cnt + 11'd1;
                     end else begin
                        oversize <= 1'b1;
                     end
                  end
               end else if (byte_cnt == 11'd14) begin
                  // Header-only frame: nothing to report.
                  state <= S_IDLE;
               end else begin
                  state      <= S_EOF;
                  arp_eof_q  <= ~chan_ipv4;
                  ipv4_eof_q <= chan_ipv4;
                  err_q      <= err_nxt;
               end
            end
            S_EOF: state <= S_IDLE;
            S_DROP: begin
               if (!rx.rx_v) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ETH_RX_DEMUX_STATS_EN
   logic        eof_fire;
   logic        drop_fire;
   logic [31:0] cnt_ok_q, cnt_drop_q, cnt_err_q;

   assign eof_fire  = (state == S_PAY) && !rx.rx_v && (byte_cnt != 11'd14);
   assign drop_fire = (state == S_HDR) && rx.rx_v && (byte_cnt == 11'd13) &&
                      !(mac_ok && (is_arp || is_ipv4));
   assign rx.cnt_ok   = cnt_ok_q;
   assign rx.cnt_drop = cnt_drop_q;
   assign rx.cnt_err  = cnt_err_q;

   // Saturating frame statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_ok_q   <= '0;
         cnt_drop_q <= '0;
         cnt_err_q  <= '0;
      end else begin
         if (eof_fire && !err_nxt && cnt_ok_q != '1)  cnt_ok_q   <= cnt_ok_q + 32'd1;
         if (eof_fire && err_nxt && cnt_err_q != '1)  cnt_err_q  <= cnt_err_q + 32'd1;
         if (drop_fire && cnt_drop_q != '1)           cnt_drop_q <= cnt_drop_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_eth_rx_demux.sv
// Testbench for eth_rx_demux. Two instances share one receive stream:
// u_dut0 (PROMISC=0, MAX_PAYLOAD=1500) and u_dut1 (PROMISC=1, MAX_PAYLOAD=16).
// A frame model pushes expected header/payload/eof events per instance;
// a monitor pops and compares them as the outputs appear.
module tb_eth_rx_demux;

   typedef struct {
      int          kind;   // 0 hdr, 1 arp byte, 2 ipv4 byte, 3 arp eof, 4 ipv4 eof
      logic [47:0] a;
      logic [47:0] b;
      logic [15:0] c;
   } ev_t;

   localparam logic [47:0] DEV_MAC = 48'h02_12_34_56_78_9A;
   localparam logic [47:0] SRC_MAC = 48'h02_AA_BB_CC_DD_EE;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTHER   = 48'h02_00_00_00_00_77;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [47:0] dev_mac = DEV_MAC;
   int          cyc = 0;

   int   n_checks = 0;
   int   n_fail = 0;
   ev_t  sb0[$];
   ev_t  sb1[$];
   logic [7:0] frm[$];
   int   t14 = 0;
   int   first_cyc0 = 0;
   logic pv0 = 1'b0;
   int   exp_ok0 = 0, exp_err0 = 0, exp_drop0 = 0;

   eth_rx_demux_if i0 ();
   eth_rx_demux_if i1 ();

   eth_rx_demux #(.MAX_PAYLOAD(1500), .PROMISC(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .dev_mac(dev_mac), .rx(i0));
   eth_rx_demux #(.MAX_PAYLOAD(16), .PROMISC(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .dev_mac(dev_mac), .rx(i1));

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input int inst, input int kind, input logic [47:0] a,
                          input logic [47:0] b, input logic [15:0] c);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b; e.c = c;
      if (inst == 0) sb0.push_back(e);
      else           sb1.push_back(e);
   endtask

   // Expected behaviour of one instance for the frame in frm; cut = bytes
   // sampled before a reset interrupted the frame (== len when none).
   task automatic model(input int inst, input bit prom, input int maxp,
                        input int len, input int cut, input bit crc);
      logic [47:0] dst, src;
      logic [15:0] typ;
      int  n, k, over;
      bit  acc, e;
      n = (cut < len) ? cut : len;
      if (n >= 14) begin
         for (int i = 0; i < 6; i++) begin
            dst[47-8*i -: 8] = frm[i];
            src[47-8*i -: 8] = frm[6+i];
         end
         typ = {frm[12], frm[13]};
         push_ev(inst, 0, dst, src, typ);
         acc = (dst == DEV_MAC || dst == BCAST || prom) &&
               (typ == 16'h0806 || typ == 16'h0800);
         if (!acc) begin
            if (inst == 0) exp_drop0++;
         end else begin
            k = 0;
            for (int j = 18; j < n; j++) begin
               if (k < maxp) begin
                  push_ev(inst, (typ == 16'h0800) ? 2 : 1, '0, '0, {8'h00, frm[j-4]});
                  k++;
               end
            end
            if (cut >= len && len > 14) begin
               over = ((len - 18) > maxp) ? 1 : 0;
               e = crc || (len < 64) || (over != 0);
               push_ev(inst, (typ == 16'h0800) ? 4 : 3, '0, '0, {15'h0, e});
               if (inst == 0) begin
                  if (e) exp_err0++;
                  else   exp_ok0++;
               end
            end
         end
      end
   endtask

   task automatic mon_ev(input int inst, input int kind, input logic [47:0] a,
                         input logic [47:0] b, input logic [15:0] c);
      ev_t e;
      int  sz;
      sz = (inst == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
         chk($sformatf("unexpected_ev%0d", inst), 64'(kind), 64'd255);
      end else begin
         if (inst == 0) e = sb0.pop_front();
         else           e = sb1.pop_front();
         chk($sformatf("ev_kind%0d", inst), 64'(kind), 64'(e.kind));
         if (kind == 0) begin
            chk($sformatf("hdr_dst%0d", inst), 64'(a), 64'(e.a));
            chk($sformatf("hdr_src%0d", inst), 64'(b), 64'(e.b));
            chk($sformatf("hdr_type%0d", inst), 64'(c), 64'(e.c));
         end else begin
            chk($sformatf("ev_data%0d_k%0d", inst, kind), 64'(c), 64'(e.c));
         end
      end
   endtask

   task automatic mon_step();
      if (i0.hdr_val)  mon_ev(0, 0, i0.hdr_dst, i0.hdr_src, i0.hdr_type);
      if (i0.arp_v)    mon_ev(0, 1, '0, '0, {8'h00, i0.out_d});
      if (i0.ipv4_v)   mon_ev(0, 2, '0, '0, {8'h00, i0.out_d});
      if (i0.arp_eof)  mon_ev(0, 3, '0, '0, {15'h0, i0.err});
      if (i0.ipv4_eof) mon_ev(0, 4, '0, '0, {15'h0, i0.err});
      if (i0.arp_v && i0.ipv4_v) chk("excl0", 64'd1, 64'd0);
      if ((i0.arp_v || i0.ipv4_v) && !pv0) first_cyc0 = cyc;
      pv0 = i0.arp_v || i0.ipv4_v;
      if (i1.hdr_val)  mon_ev(1, 0, i1.hdr_dst, i1.hdr_src, i1.hdr_type);
      if (i1.arp_v)    mon_ev(1, 1, '0, '0, {8'h00, i1.out_d});
      if (i1.ipv4_v)   mon_ev(1, 2, '0, '0, {8'h00, i1.out_d});
      if (i1.arp_eof)  mon_ev(1, 3, '0, '0, {15'h0, i1.err});
      if (i1.ipv4_eof) mon_ev(1, 4, '0, '0, {15'h0, i1.err});
      if (i1.arp_v && i1.ipv4_v) chk("excl1", 64'd1, 64'd0);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic crc);
      i0.rx_v = v; i0.rx_d = d; i0.rx_crc_err = crc;
      i1.rx_v = v; i1.rx_d = d; i1.rx_crc_err = crc;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hdr0"}, 64'(|{i0.hdr_dst, i0.hdr_src, i0.hdr_type}), 64'd0);
      chk({tag, "_out0"}, 64'({i0.out_d, i0.hdr_val, i0.arp_v, i0.ipv4_v,
                               i0.arp_eof, i0.ipv4_eof, i0.err}), 64'd0);
      chk({tag, "_hdr1"}, 64'(|{i1.hdr_dst, i1.hdr_src, i1.hdr_type}), 64'd0);
      chk({tag, "_out1"}, 64'({i1.out_d, i1.hdr_val, i1.arp_v, i1.ipv4_v,
                               i1.arp_eof, i1.ipv4_eof, i1.err}), 64'd0);
   endtask

   task automatic send_frame(input int len, input logic [47:0] dst, input logic [15:0] typ,
                             input bit crc, input int rst_at);
      int cut;
      frm.delete();
      for (int k = 0; k < len; k++) begin
         if (k < 6)        frm.push_back(dst[47-8*k -: 8]);
         else if (k < 12)  frm.push_back(SRC_MAC[47-8*(k-6) -: 8]);
         else if (k == 12) frm.push_back(typ[15:8]);
         else if (k == 13) frm.push_back(typ[7:0]);
         else              frm.push_back(8'($urandom_range(0, 255)));
      end
      cut = (rst_at >= 0) ? rst_at : len;
      model(0, 1'b0, 1500, len, cut, crc);
      model(1, 1'b1, 16, len, cut, crc);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         if (k == 14) t14 = cyc;
         drive(1'b1, frm[k], 1'b0);
         if (rst_at >= 0 && k == rst_at + 1) rst = 1'b1;
         if (k == rst_at) begin
            #1 rst = 1'b0;
            #1 chk_zero("mid_rst");
            exp_ok0 = 0; exp_err0 = 0; exp_drop0 = 0;
         end
      end
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 8'h00, crc);
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0);
      repeat (11) @(negedge clk);
      chk("sb0_left", 64'(sb0.size()), 64'd0);
      chk("sb1_left", 64'(sb1.size()), 64'd0);
      sb0.delete();
      sb1.delete();
   endtask

   initial begin
      drive(1'b0, 8'h00, 1'b0);
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      repeat (4) @(negedge clk);

      send_frame(64, DEV_MAC, 16'h0806, 1'b0, -1);   // unicast ARP, good
      send_frame(100, BCAST, 16'h0800, 1'b0, -1);    // broadcast IPv4
      chk("latency", 64'(first_cyc0 - t14), 64'd5);
      send_frame(64, OTHER, 16'h0800, 1'b0, -1);     // foreign MAC
`ifdef ETH_RX_DEMUX_STATS_EN
      chk("cnt_drop_after_filter", 64'(i0.cnt_drop), 64'(exp_drop0));
`endif
      send_frame(64, DEV_MAC, 16'h0800, 1'b1, -1);   // CRC error
      send_frame(40, DEV_MAC, 16'h0800, 1'b0, -1);   // runt
      send_frame(200, DEV_MAC, 16'h0800, 1'b0, -1);  // oversize on u_dut1
      send_frame(10, DEV_MAC, 16'h0800, 1'b0, -1);   // short: no header
      send_frame(64, DEV_MAC, 16'h86DD, 1'b0, -1);   // unknown ethertype
`ifdef ETH_RX_DEMUX_STATS_EN
      chk("cnt_ok", 64'(i0.cnt_ok), 64'(exp_ok0));
      chk("cnt_err", 64'(i0.cnt_err), 64'(exp_err0));
      chk("cnt_drop", 64'(i0.cnt_drop), 64'(exp_drop0));
`endif
      send_frame(80, DEV_MAC, 16'h0800, 1'b0, 30);   // reset mid-frame
      send_frame(64, DEV_MAC, 16'h0806, 1'b0, -1);   // recovery
`ifdef ETH_RX_DEMUX_STATS_EN
      chk("cnt_ok_end", 64'(i0.cnt_ok), 64'(exp_ok0));
      chk("cnt_err_end", 64'(i0.cnt_err), 64'(exp_err0));
      chk("cnt_drop_end", 64'(i0.cnt_drop), 64'(exp_drop0));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_rx_demux.md
Name: eth_rx_demux

Overview:
- Receive-side counterpart of the TX header/stream arbiter that merges ARP and IPv4 traffic into the MAC.
- Takes the de-preambled GMII byte stream from the MAC RX path and parses the 14-byte Ethernet header.
- Filters frames by destination MAC, strips the 4-byte FCS, and steers the payload to either the ARP or the IPv4 consumer by ethertype.
- Flags CRC, runt and oversize errors at end of frame.

Parameters:
- MAX_PAYLOAD, 1500: maximum number of payload bytes forwarded per frame; bytes beyond this are not forwarded.
- PROMISC, 0: 1 = accept any destination MAC.

Ports:
- clk  in  1  system clock, 125 MHz
- rst  in  1  asynchronous, active-low reset
- dev_mac  in  48  local MAC address
- rx_d  in  8  frame byte (dst MAC first, FCS last)
- rx_v  in  1  high for every byte of a frame, contiguous, no gaps
- rx_crc_err  in  1  sampled only in the first cycle with rx_v low after a frame
- hdr_dst  out  48  captured destination MAC
- hdr_src  out  48  captured source MAC
- hdr_type  out  16  captured ethertype
- hdr_val  out  1  one-cycle strobe; header fields are valid from this cycle
- out_d  out  8  payload byte, shared by both channels
- arp_v  out  1  out_d is an ARP payload byte
- ipv4_v  out  1  out_d is an IPv4 payload byte
- arp_eof  out  1  one-cycle end-of-frame strobe, ARP channel
- ipv4_eof  out  1  one-cycle end-of-frame strobe, IPv4 channel
- err  out  1  qualifies arp_eof/ipv4_eof; frame must be discarded

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; header registers 0; byte counter 0; rx_v_q 0.
- Frame start: a frame starts only on a rising edge of rx_v (rx_v=1, rx_v_q=0). A frame already in progress when reset is released is ignored until rx_v goes low.
- Byte counter: 11-bit, counts bytes of the current frame, saturates at 2047.
- States:
  - IDLE -> HDR on frame start.
  - HDR: shift bytes 0..13 into dst, src, type, MSB first. After byte 13 is sampled, hdr_val pulses on the next cycle.
  - Filter on byte 13: the destination must be dev_mac, or FF:FF:FF:FF:FF:FF, or PROMISC=1.
    - Accept and type 0x0806 -> PAY with channel ARP.
    - Accept and type 0x0800 -> PAY with channel IPv4.
    - Otherwise -> DROP. hdr_val still pulses.
  - PAY: bytes pass through a 4-deep delay line. Byte k (k>=14) is presented on out_d with its channel valid in the cycle after byte k+4 is sampled. This strips the FCS with no extra state.
  - Oversize: once MAX_PAYLOAD bytes have been forwarded, the channel valid stays low for the rest of the frame and an oversize flag is set.
  - PAY -> EOF on the first cycle with rx_v=0. In EOF, rx_crc_err is sampled and the channel eof pulses one cycle with err = crc_err | runt | oversize, where runt means total bytes < 64.
  - EOF -> IDLE.
  - DROP: no outputs; -> IDLE when rx_v=0. No eof is issued for dropped frames.
- Short frames: if rx_v falls in HDR (frame of 14 bytes or fewer), go to IDLE with no eof.
- Channel exclusivity: arp_v and ipv4_v are never high together. Neither is high outside PAY.
- Inter-frame gap: at least 2 idle cycles between frames (GMII guarantees 12). A rising edge of rx_v during EOF is unsupported.
- Header fields hold their values until the next frame's byte 0.

Optional Feature:
- Macro ETH_RX_DEMUX_STATS_EN.
- When defined, add three outputs: cnt_ok, cnt_drop, cnt_err, each 32 bits, saturating, reset to 0.
  - cnt_ok increments on eof with err=0.
  - cnt_err increments on eof with err=1.
  - cnt_drop increments on entry to DROP.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- 64-byte unicast to dev_mac with type 0x0806 and good CRC -> hdr_val once; exactly 46 arp_v bytes equal to input bytes 14..59; arp_eof with err=0; ipv4_v never high.
- Broadcast frame with type 0x0800, 100 bytes -> 82 ipv4_v bytes; ipv4_eof; first payload byte appears 5 cycles after input byte 14.
- Frame to another MAC, PROMISC=0 -> hdr_val pulses; no v and no eof. With STATS_EN, cnt_drop=1. With PROMISC=1 the same frame is forwarded.
- Type 0x0800, 64 bytes, rx_crc_err=1 at EOF -> 46 bytes forwarded; ipv4_eof with err=1. Same with a 40-byte frame (runt) and err=1.
- MAX_PAYLOAD=16 with a 200-byte frame -> exactly 16 valid bytes; eof with err=1.
- rst low for 1 cycle at byte 30, released mid-frame -> all outputs 0 at once; rest of frame ignored; next frame after a 12-cycle gap parses correctly.
